// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg
// Shared definitions for the fetch PC slice: sequencing state encoding,
// default address width, BIOS ROM bound, return-stack depth and the CMB
// opcode value that decode recognises before raising the cmb strobe.
package fetch_pc_unit_pkg;

    localparam int unsigned FETCH_ADDR_W      = 32;
    localparam int unsigned FETCH_BIOS_LAST   = 1130;
    localparam int unsigned FETCH_STACK_DEPTH = 4;

    // Change-to-main-memory opcode
    localparam logic [5:0] OPC_CMB = 6'b100101;

    typedef enum logic [1:0] {
        ST_BIOS,
        ST_MAIN,
        ST_WAIT,
        ST_FAULT
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if
// Decode-to-fetch control bundle.
//   master : decode side, drives enable and the control strobes/targets,
//            observes pc, bios_sel, halted and fault.
//   slave  : fetch_pc_unit side.
// call/ret are always present; they only act when the unit is built with
// FETCH_PC_CALL_STACK_EN.
interface fetch_pc_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              enable;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              cmb;
    logic              halt;
    logic              resume;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] pc;
    logic              bios_sel;
    logic              halted;
    logic              fault;

    modport master (
        output enable, branch_taken, branch_target, jump, jump_target,
               cmb, halt, resume, call, ret,
        input  pc, bios_sel, halted, fault
    );

    modport slave (
        input  enable, branch_taken, branch_target, jump, jump_target,
               cmb, halt, resume, call, ret,
        output pc, bios_sel, halted, fault
    );
endinterface

// File: rtl/fetch_return_stack.sv
// fetch_return_stack
// LIFO of return addresses used by the call/ret strobes of fetch_pc_unit
// (only instantiated when FETCH_PC_CALL_STACK_EN is defined).
// Ports:
//   clock, reset      clock; synchronous active-low reset (empties stack)
//   push, push_data   store push_data on top (ignored when full)
//   pop               discard top entry (ignored when empty)
//   top_data          current top entry ('0 when empty)
//   full, empty       occupancy flags
module fetch_return_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
)(
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic         full,
    output logic         empty
);
    localparam int unsigned SP_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp;

    assign full     = (sp == SP_W'(DEPTH));
    assign empty    = (sp == '0);
    assign top_data = empty ? '0 : mem[IDX_W'(sp - 1'b1)];

    always_ff @(posedge clock) begin
        if (!reset) begin
            sp <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[IDX_W'(sp)] <= push_data;
            sp              <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// Program counter and fetch sequencing for the BIOS ROM / main memory.
// Boots in BIOS at address 0; cmb hands over to main memory at address 0.
// Ports:
//   clock  clock
//   reset  synchronous, active-low
//   bus    fetch_pc_unit_if.slave: enable, branch_taken/branch_target,
//          jump/jump_target, cmb, halt, resume, call, ret (inputs);
//          pc, bios_sel, halted, fault (registered outputs)
// Build option: define FETCH_PC_CALL_STACK_EN to add a STACK_DEPTH-entry
// return stack driven by call/ret; otherwise call/ret are ignored.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned ADDR_W      = FETCH_ADDR_W,
    parameter int unsigned BIOS_LAST   = FETCH_BIOS_LAST,
    parameter int unsigned STACK_DEPTH = FETCH_STACK_DEPTH
)(
    input logic            clock,
    input logic            reset,
    fetch_pc_unit_if.slave bus
);
    localparam logic [ADDR_W-1:0] BIOS_LAST_A = ADDR_W'(BIOS_LAST);

    fetch_state_e      state, state_n;
    fetch_state_e      saved_mode, saved_n;
    logic [ADDR_W-1:0] pc, pc_n, cand;
    logic              bios_sel, bios_sel_n;
    logic              stack_fault;

`ifdef FETCH_PC_CALL_STACK_EN
    logic              stk_push, stk_pop, stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_top;

    fetch_return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc + 1'b1),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );
`else
    localparam int unsigned UNUSED_STACK_DEPTH = STACK_DEPTH;
    logic unused_call_ret;
    assign unused_call_ret = bus.call | bus.ret;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_BIOS;
            saved_mode <= ST_BIOS;
            pc         <= '0;
            bios_sel   <= 1'b1;
        end else begin
            state      <= state_n;
            saved_mode <= saved_n;
            pc         <= pc_n;
            bios_sel   <= bios_sel_n;
        end
    end

    always_comb begin
        state_n     = state;
        saved_n     = saved_mode;
        pc_n        = pc;
        bios_sel_n  = bios_sel;
        cand        = pc + 1'b1;
        stack_fault = 1'b0;
`ifdef FETCH_PC_CALL_STACK_EN
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
`endif
        if (bus.enable) begin
            unique case (state)
                ST_BIOS, ST_MAIN: begin
                    if (bus.halt) begin
                        saved_n = state;
                        state_n = ST_WAIT;
                    end else if (bus.cmb) begin
                        pc_n       = '0;
                        state_n    = ST_MAIN;
                        bios_sel_n = 1'b0;
                    end else begin
                        if (bus.jump) begin
                            cand = bus.jump_target;
                        end else if (bus.branch_taken) begin
                            cand = bus.branch_target;
                        end
`ifdef FETCH_PC_CALL_STACK_EN
                        // ret/call outrank jump/branch, so they override the
                        // candidate chosen above.
                        if (bus.ret) begin
                            cand        = stk_top;
                            stack_fault = stk_empty;
                        end else if (bus.call) begin
                            cand        = bus.jump_target;
                            stack_fault = stk_full;
                        end
`endif
                        // A BIOS-mode pc beyond the ROM faults; pc is kept.
                        if (stack_fault || (state == ST_BIOS && cand > BIOS_LAST_A)) begin
                            state_n = ST_FAULT;
                        end else begin
                            pc_n = cand;
`ifdef FETCH_PC_CALL_STACK_EN
                            stk_pop  = bus.ret;
                            stk_push = bus.call && !bus.ret;
`endif
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.resume) begin
                        if (saved_mode == ST_BIOS && cand > BIOS_LAST_A) begin
                            state_n = ST_FAULT;
                        end else begin
                            pc_n    = cand;
                            state_n = saved_mode;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc       = pc;
    assign bus.bios_sel = bios_sel;
    assign bus.halted   = (state == ST_WAIT);
    assign bus.fault    = (state == ST_FAULT);
endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;
    localparam int unsigned AW    = 32;
    localparam int unsigned LAST  = 1130;
    localparam int unsigned DEPTH = 4;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    fetch_pc_unit_if #(.ADDR_W(AW)) bus ();

    fetch_pc_unit #(
        .ADDR_W      (AW),
        .BIOS_LAST   (LAST),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          rst_n;
        logic          en;
        logic          br;
        logic [AW-1:0] bt;
        logic          jmp;
        logic [AW-1:0] jt;
        logic          cmb;
        logic          halt;
        logic          resume;
        logic          call;
        logic          ret;
    } stim_t;

    typedef struct {
        logic [AW-1:0] pc;
        logic          bsel;
        logic          halted;
        logic          fault;
    } exp_t;

    typedef enum {M_BIOS, M_MAIN, M_WAIT, M_FAULT} mode_e;

    exp_t          exp_q[$];
    int            checks   = 0;
    int            failures = 0;

    // Reference model state
    mode_e         mode  = M_BIOS;
    mode_e         saved = M_BIOS;
    logic [AW-1:0] mpc   = '0;
    logic          mbios = 1'b1;
    logic [AW-1:0] stk[$];

    task automatic model_step(input stim_t s);
        logic [AW-1:0] nxt;
        bit            bad;
        if (!s.rst_n) begin
            mode  = M_BIOS;
            saved = M_BIOS;
            mpc   = '0;
            mbios = 1'b1;
            stk.delete();
        end else if (s.en) begin
            case (mode)
                M_BIOS, M_MAIN: begin
                    if (s.halt) begin
                        saved = mode;
                        mode  = M_WAIT;
                    end else if (s.cmb) begin
                        mpc   = '0;
                        mode  = M_MAIN;
                        mbios = 1'b0;
                    end else begin
                        bad = 0;
                        nxt = mpc + 1;
`ifdef FETCH_PC_CALL_STACK_EN
                        if (s.ret) begin
                            if (stk.size() == 0) bad = 1;
                            else nxt = stk.pop_back();
                        end else if (s.call) begin
                            if (stk.size() == DEPTH) bad = 1;
                            else begin
                                stk.push_back(mpc + 1);
                                nxt = s.jt;
                            end
                        end else
`endif
                        if (s.jmp) nxt = s.jt;
                        else if (s.br) nxt = s.bt;
                        if (!bad && mode == M_BIOS && nxt > LAST) bad = 1;
                        if (bad) mode = M_FAULT;
                        else mpc = nxt;
                    end
                end
                M_WAIT: begin
                    if (s.resume) begin
                        nxt = mpc + 1;
                        if (saved == M_BIOS && nxt > LAST) mode = M_FAULT;
                        else begin
                            mpc  = nxt;
                            mode = saved;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1; s.en = 1'b1; s.br = 1'b0; s.bt = '0; s.jmp = 1'b0;
        s.jt = '0; s.cmb = 1'b0; s.halt = 1'b0; s.resume = 1'b0;
        s.call = 1'b0; s.ret = 1'b0;
        return s;
    endfunction

    task automatic cyc(input stim_t s);
        exp_t e;
        @(negedge clock);
        reset             = s.rst_n;
        bus.enable        = s.en;
        bus.branch_taken  = s.br;
        bus.branch_target = s.bt;
        bus.jump          = s.jmp;
        bus.jump_target   = s.jt;
        bus.cmb           = s.cmb;
        bus.halt          = s.halt;
        bus.resume        = s.resume;
        bus.call          = s.call;
        bus.ret           = s.ret;
        model_step(s);
        e.pc     = mpc;
        e.bsel   = mbios;
        e.halted = (mode == M_WAIT);
        e.fault  = (mode == M_FAULT);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        stim_t s = idle();
        s.rst_n = 1'b0;
        s.jmp = 1'b1; s.jt = 32'd77; s.halt = 1'b1;
        cyc(s);
        cyc(s);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) cyc(idle());
    endtask

    task automatic jump_to(input logic [AW-1:0] t);
        stim_t s = idle();
        s.jmp = 1'b1; s.jt = t;
        cyc(s);
    endtask

    // Monitor: every clock the DUT presents a registered result; compare it
    // against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.pc !== e.pc) begin
                    failures++;
                    $display("FAIL pc: got %0h expected %0h at %0t", bus.pc, e.pc, $time);
                end
                checks++;
                if (bus.bios_sel !== e.bsel) begin
                    failures++;
                    $display("FAIL bios_sel: got %b expected %b at %0t", bus.bios_sel, e.bsel, $time);
                end
                checks++;
                if (bus.halted !== e.halted) begin
                    failures++;
                    $display("FAIL halted: got %b expected %b at %0t", bus.halted, e.halted, $time);
                end
                checks++;
                if (bus.fault !== e.fault) begin
                    failures++;
                    $display("FAIL fault: got %b expected %b at %0t", bus.fault, e.fault, $time);
                end
            end
        end
    end

    initial begin
        stim_t s;
        int    guard;

        reset = 1'b0;
        bus.enable = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
        bus.jump = 1'b0; bus.jump_target = '0; bus.cmb = 1'b0; bus.halt = 1'b0;
        bus.resume = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;

        // Boot, count, reset mid-run
        do_reset();
        incs(3);
        do_reset();
        incs(2);

        // enable low holds everything
        s = idle(); s.en = 1'b0; s.jmp = 1'b1; s.jt = 32'd99; s.cmb = 1'b1; s.halt = 1'b1;
        cyc(s); cyc(s);

        // Branch / jump priority
        do_reset();
        incs(16);
        s = idle(); s.br = 1'b1; s.bt = 32'd13; cyc(s);
        s = idle(); s.jmp = 1'b1; s.jt = 32'd5; s.br = 1'b1; s.bt = 32'd9; cyc(s);

        // CMB handover, main counting, wrap
        jump_to(32'd43);
        s = idle(); s.cmb = 1'b1; cyc(s);
        incs(2);
        jump_to(32'hFFFF_FFFF);
        incs(2);
        s = idle(); s.cmb = 1'b1; s.jmp = 1'b1; s.jt = 32'd8; cyc(s);

        // Halt/resume in BIOS, including halt+resume together
        do_reset();
        incs(7);
        s = idle(); s.halt = 1'b1; s.resume = 1'b1; cyc(s);
        for (int i = 0; i < 10; i++) begin
            s = idle(); s.jmp = 1'b1; s.jt = 32'd3; s.cmb = (i == 4); s.br = 1'b1; s.bt = 32'd2;
            cyc(s);
        end
        s = idle(); s.resume = 1'b1; cyc(s);
        incs(1);

        // Halt/resume in MAIN
        s = idle(); s.cmb = 1'b1; cyc(s);
        jump_to(32'd7);
        s = idle(); s.halt = 1'b1; cyc(s);
        incs(3);
        s = idle(); s.resume = 1'b1; cyc(s);

        // BIOS upper bound: last address OK, increment beyond faults
        do_reset();
        jump_to(32'd1130);
        incs(1);
        s = idle(); s.resume = 1'b1; s.cmb = 1'b1; cyc(s);
        jump_to(32'd5);
        do_reset();
        jump_to(32'd1131);
        incs(1);

`ifdef FETCH_PC_CALL_STACK_EN
        // Return stack
        do_reset();
        jump_to(32'd10);
        s = idle(); s.call = 1'b1; s.jt = 32'd40; cyc(s);
        s = idle(); s.ret = 1'b1; cyc(s);
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.call = 1'b1; s.jt = 32'd100 + 32'(i); cyc(s);
        end
        do_reset();
        s = idle(); s.ret = 1'b1; cyc(s);
`endif

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            s.rst_n  = ($urandom_range(0, 59) != 0);
            s.en     = ($urandom_range(0, 3) != 0);
            s.halt   = ($urandom_range(0, 19) == 0);
            s.resume = ($urandom_range(0, 2) == 0);
            s.cmb    = ($urandom_range(0, 29) == 0);
            s.jmp    = ($urandom_range(0, 5) == 0);
            s.br     = ($urandom_range(0, 4) == 0);
            s.call   = ($urandom_range(0, 7) == 0);
            s.ret    = ($urandom_range(0, 7) == 0);
            s.jt     = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(0, 1)))
                                                   : 32'($urandom_range(0, 1200));
            s.bt     = 32'($urandom_range(0, 1200));
            cyc(s);
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clock);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and fetch-sequencing stage directly upstream of the BIOS instruction ROM and main instruction memory. Drives the fetch address and a BIOS/main source select. Advances, branches, jumps, halts and performs the BIOS-to-main handover (CMB) from control strobes supplied by decode. Boot always starts at BIOS address 0; after CMB the same counter indexes main memory from 0.

## Interface
- ADDR_W, 32, fetch address width
- BIOS_LAST, 1130, highest valid BIOS ROM address
- STACK_DEPTH, 4, return-stack entries (only with call stack compiled in)

- clock  in  1  clock
- reset  in  1  reset, synchronous, active-low
- enable  in  1  one-cycle step strobe; all updates happen only when high
- branch_taken  in  1  conditional branch resolved taken
- branch_target  in  ADDR_W  branch destination
- jump  in  1  unconditional jump
- jump_target  in  ADDR_W  jump destination
- cmb  in  1  change to main memory (CMB opcode 100101)
- halt  in  1  stop fetching (wait for input device)
- resume  in  1  input device confirm; leaves halt
- call / ret  in  1 / 1  push PC+1 and jump / pop (call stack build only)
- pc  out  ADDR_W  fetch address to ROM/memory
- bios_sel  out  1  1 = fetch from BIOS ROM, 0 = main memory
- halted  out  1  high in WAIT
- fault  out  1  sticky error flag

## Operation
- States: BIOS, MAIN, WAIT, FAULT. Reset → BIOS, pc=0, bios_sel=1, halted=0, fault=0, stack pointer=0, saved_mode=BIOS.
- BIOS/MAIN with enable=1, priority: halt > cmb > ret > call > jump > branch_taken > increment.
  - halt: saved_mode←current, → WAIT, pc held.
  - cmb: pc←0, → MAIN, bios_sel←0 (from MAIN: pc←0, stays MAIN).
  - jump: pc←jump_target; branch_taken: pc←branch_target; else pc←pc+1.
- WAIT: pc held, halted=1; resume=1 with enable=1 → saved_mode, pc←pc+1. Other strobes ignored.
- FAULT: pc held, fault=1, all strobes ignored until reset.
- Any new pc (target or increment) above BIOS_LAST while in BIOS → FAULT, pc unchanged.
- MAIN increment wraps modulo 2^ADDR_W (all-ones → 0), no fault.
- enable=0: all state and outputs held regardless of strobes.

## Timing
- Registered outputs; new pc visible one clock after the enable edge; ROM samples it on its next edge (single-cycle fetch latency from this block).
- bios_sel changes in the same cycle as pc←0 on cmb; never glitches between them.
- Reset mid-operation (any state, any strobe) wins; reset values on the next edge.
- halt and resume in the same cycle from BIOS/MAIN: halt taken, resume ignored.

## Configuration
- FETCH_PC_CALL_STACK_EN defined: STACK_DEPTH-entry return stack; call pushes pc+1 and loads jump_target; ret pops into pc; push when full or pop when empty → FAULT. Stack cleared on reset, preserved across cmb.
- Undefined: call/ret ports present but ignored; no stack storage.

## Structure
- Shared package: state encoding, opcode constant CMB=6'b100101, ADDR_W default, BIOS_LAST.
- One sub-module natural: fetch_return_stack (LIFO, push/pop/full/empty), instantiated only under the macro.

## Test plan
- Reset then 3 enables → pc=3, bios_sel=1; reset asserted mid-run → pc=0, state BIOS next edge.
- branch_taken target=13 at pc=16 → pc=13; jump and branch same cycle (targets 5/9) → pc=5.
- cmb at pc=43 → pc=0, bios_sel=0; 2 enables → pc=2; pc=0xFFFFFFFF increment → pc=0, fault=0.
- halt at pc=7 → halted=1, pc=7 for 10 enables; resume → pc=8, halted=0, mode preserved (BIOS and MAIN both checked).
- BIOS pc=1130 increment → fault=1, pc=1130; subsequent strobes ignored until reset.
- Macro on: call target 40 at pc=10 → pc=40; ret → pc=11; 5 nested calls (depth 4) → fault=1; ret on empty → fault=1.
